// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: async-assert/sync-deassert reset, stretched sync reset and a
// ready qualifier, released in order HOLD -> SRST -> SETTLE -> RUN.
module rst_seq_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SRST_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic       i_swrst,
  output logic       o_arst,
  output logic       o_srst,
  output logic       o_ready,
  output logic [1:0] o_state,
  output logic [7:0] o_rst_count
);

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_SRST   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  localparam logic [CNT_W-1:0] SRST_LOAD   = CNT_W'(SRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       COUNT_MAX   = 8'hFF;

  // Chain holds the inverted sync value so o_arst comes straight off the last flop.
  logic [SYNC_STAGES-1:0] arst_chain;
  logic                   sync_q;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       count_nxt;
  logic             srst_nxt, ready_nxt;

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      arst_chain <= '1;
    end else begin
      arst_chain <= {arst_chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign o_arst = arst_chain[SYNC_STAGES-1];
  assign sync_q = ~arst_chain[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      o_rst_count <= '0;
      o_srst      <= 1'b1;
      o_ready     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_rst_count <= count_nxt;
      o_srst      <= srst_nxt;
      o_ready     <= ready_nxt;
    end
  end

  assign o_state = state;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    count_nxt = o_rst_count;
    srst_nxt  = 1'b1;
    ready_nxt = 1'b0;

    case (state)
      ST_HOLD: begin
        if (sync_q) begin
          state_nxt = ST_SRST;
          cnt_nxt   = SRST_LOAD;
        end
      end
      ST_SRST: begin
        if (cnt == '0) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (i_swrst) begin
          state_nxt = ST_SRST;
          cnt_nxt   = SRST_LOAD;
          if (o_rst_count != COUNT_MAX) begin
            count_nxt = o_rst_count + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        cnt_nxt   = '0;
      end
    endcase

    srst_nxt  = (state_nxt == ST_HOLD) || (state_nxt == ST_SRST);
    ready_nxt = (state_nxt == ST_RUN);
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: default and minimum-parameter instances
// checked every cycle against an edge-number based timing model.
module tb_rst_seq_ctrl;

  localparam int SYNC_S = 2;

  logic clk;
  logic arst;
  logic swrst;

  logic       o_arst0, o_srst0, o_ready0;
  logic [1:0] o_state0;
  logic [7:0] o_cnt0;
  logic       o_arst1, o_srst1, o_ready1;
  logic [1:0] o_state1;
  logic [7:0] o_cnt1;

  int checks = 0;
  int passed = 0;

  rst_seq_ctrl #(.SYNC_STAGES(2), .SRST_CYCLES(4), .SETTLE_CYCLES(8), .CNT_W(8)) dut0 (
    .i_clk(clk), .i_arst(arst), .i_swrst(swrst),
    .o_arst(o_arst0), .o_srst(o_srst0), .o_ready(o_ready0),
    .o_state(o_state0), .o_rst_count(o_cnt0)
  );

  rst_seq_ctrl #(.SYNC_STAGES(2), .SRST_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_arst(arst), .i_swrst(swrst),
    .o_arst(o_arst1), .o_srst(o_srst1), .o_ready(o_ready1),
    .o_state(o_state1), .o_rst_count(o_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each sequence is a set of absolute edge numbers at which
  // the phases begin; outputs follow from where the current edge falls.
  int sr_c [2] = '{4, 1};
  int se_c [2] = '{8, 1};
  int n [2];
  int srst_start [2];
  int settle_start [2];
  int run_at [2];
  int cnt_m [2];
  int seen_ev [2] = '{0, 0};
  int rst_ev = 0;

  logic [12:0] q0 [$];
  logic [12:0] q1 [$];

  always @(negedge arst) rst_ev++;

  function automatic int phase_at(int d, int k);
    if (k < srst_start[d]) return 0;
    if (k < settle_start[d]) return 1;
    if (k < run_at[d]) return 2;
    return 3;
  endfunction

  function automatic logic [12:0] expect_now(int d);
    int ph;
    ph = phase_at(d, n[d]);
    return {(n[d] < SYNC_S), (ph <= 1), (ph == 3), 2'(ph), 8'(cnt_m[d])};
  endfunction

  task automatic model_step(int d);
    int prev;
    if (!arst || seen_ev[d] != rst_ev) begin
      seen_ev[d]      = rst_ev;
      n[d]            = 0;
      cnt_m[d]        = 0;
      srst_start[d]   = SYNC_S + 1;
      settle_start[d] = SYNC_S + 1 + sr_c[d];
      run_at[d]       = settle_start[d] + se_c[d];
    end
    if (arst) begin
      prev = phase_at(d, n[d]);
      n[d]++;
      if (prev == 3 && swrst) begin
        srst_start[d]   = n[d];
        settle_start[d] = n[d] + sr_c[d];
        run_at[d]       = settle_start[d] + se_c[d];
        if (cnt_m[d] < 255) cnt_m[d]++;
      end
    end
  endtask

  // Stimulus side of the scoreboard: predict each edge's outcome.
  always @(posedge clk) begin
    model_step(0);
    q0.push_back(expect_now(0));
    model_step(1);
    q1.push_back(expect_now(1));
  end

  task automatic chk(string nm, logic [12:0] act, logic [12:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0t got arst=%b srst=%b ready=%b state=%0d count=%0d want arst=%b srst=%b ready=%b state=%0d count=%0d",
                  nm, $time, act[12], act[11], act[10], act[9:8], act[7:0],
                  exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
  endtask

  // Monitor: outputs are presented every cycle; compare away from the edge.
  always @(negedge clk) begin
    if (q0.size() > 0) chk("dut0_cycle", {o_arst0, o_srst0, o_ready0, o_state0, o_cnt0}, q0.pop_front());
    if (q1.size() > 0) chk("dut1_cycle", {o_arst1, o_srst1, o_ready1, o_state1, o_cnt1}, q1.pop_front());
  end

  task automatic check_reset_now();
    chk("dut0_async_reset", {o_arst0, o_srst0, o_ready0, o_state0, o_cnt0}, 13'b1_1_0_00_00000000);
    chk("dut1_async_reset", {o_arst1, o_srst1, o_ready1, o_state1, o_cnt1}, 13'b1_1_0_00_00000000);
  endtask

  // Mid-cycle reset held for some cycles, released at a falling edge.
  task automatic do_reset(int cycles);
    @(negedge clk);
    #1 arst = 1'b0;
    #1 check_reset_now();
    repeat (cycles) @(negedge clk);
    arst = 1'b1;
  endtask

  // Sub-cycle reset pulse that never spans a rising edge.
  task automatic glitch();
    @(negedge clk);
    #1 arst = 1'b0;
    #1 check_reset_now();
    #1 arst = 1'b1;
  endtask

  task automatic random_swrst(int cycles);
    repeat (cycles) begin
      swrst = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    swrst = 1'b0;
  endtask

  initial begin
    arst  = 1'b1;
    swrst = 1'b0;
    #1 arst = 1'b0;
    #1 check_reset_now();
    repeat (3) @(negedge clk);
    arst = 1'b1;
    repeat (20) @(negedge clk);

    random_swrst(300);
    repeat (15) @(negedge clk);

    // Request during SRST/SETTLE is ignored, then retriggers on each RUN entry.
    do_reset(2);
    repeat (3) @(negedge clk);
    swrst = 1'b1;
    repeat (40) @(negedge clk);
    swrst = 1'b0;
    repeat (20) @(negedge clk);

    // Drop reset half a cycle after edge 10 (inside SETTLE).
    do_reset(1);
    repeat (9) @(negedge clk);
    do_reset(2);
    repeat (20) @(negedge clk);

    glitch();
    repeat (20) @(negedge clk);
    random_swrst(100);

    // Saturate the software-reset counter.
    repeat (15) @(negedge clk);
    swrst = 1'b1;
    repeat (260 * 13 + 20) @(negedge clk);
    swrst = 1'b0;
    repeat (20) @(negedge clk);
    chk("dut0_saturated", {5'b0, o_cnt0}, 13'd255);
    chk("dut1_saturated", {5'b0, o_cnt1}, 13'd255);
    random_swrst(100);

    repeat (3) @(negedge clk);
    #1 $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
